// File: rtl/matmul_loader_pkg.sv
// Shared types and default sizing for the matmul host loader.
// Word width is BB_MAT_MUL_SIZE*DWIDTH; the top recomputes it from its own parameters.
package matmul_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        SETTLE,
        RUN,
        FINISH
    } state_t;

    localparam int LDR_DWIDTH  = 8;
    localparam int LDR_BB_SIZE = 32;
    localparam int W           = LDR_BB_SIZE * LDR_DWIDTH;

    function automatic int word_width(input int bb_size, input int dwidth);
        return bb_size * dwidth;
    endfunction

endpackage

// File: rtl/loader_beat_counter.sv
// Per-phase word index: cleared at the start of each load phase, bumped per accepted beat.
// tc_o flags that the current index is the phase's last word.
module loader_beat_counter #(
    parameter int CWIDTH = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [CWIDTH-1:0] last_i,
    output logic [CWIDTH-1:0] idx_o,
    output logic              tc_o
);

    logic [CWIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign idx_o = cnt_q;
    assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/matmul_host_loader.sv
// Streams A then B words into the matmul BRAMs, then holds start_mat_mul until done.
// Optional RUN watchdog with sticky timeout_err when LOADER_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for cmd_go
// LOAD_A | accepting A_WORDS beats, strobing we_a
// LOAD_B | accepting B_WORDS beats, strobing we_b
// SETTLE | SETTLE_CYCLES quiet cycles for the address pipeline
// RUN    | start_mat_mul held until done_mat_mul
// FINISH | one-cycle done_pulse
module matmul_host_loader
    import matmul_loader_pkg::*;
#(
    parameter int DWIDTH          = LDR_DWIDTH,
    parameter int BB_MAT_MUL_SIZE = LDR_BB_SIZE,
    parameter int AWIDTH          = 7,
    parameter int A_WORDS         = 64,
    parameter int B_WORDS         = 64,
    parameter int SETTLE_CYCLES   = 2
`ifdef LOADER_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cmd_go,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] s_data,
    output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] data_pi,
    output logic [AWIDTH-1:0]                 addr_pi,
    output logic                              we_a,
    output logic                              we_b,
    output logic                              enable_writing_to_mem,
    output logic                              start_mat_mul,
    input  logic                              done_mat_mul,
    output logic                              busy,
    output logic                              done_pulse,
    output logic                              timeout_err
);

    localparam int                WW          = word_width(BB_MAT_MUL_SIZE, DWIDTH);
    localparam logic [AWIDTH-1:0] A_LAST      = AWIDTH'(A_WORDS - 1);
    localparam logic [AWIDTH-1:0] B_LAST      = AWIDTH'(B_WORDS - 1);
    localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [WW-1:0]     data_q;
    logic [AWIDTH-1:0] addr_q;
    logic              we_a_q, we_b_q, en_q;
    logic [7:0]        settle_q;
    logic              accept, last_beat, beat_tc;
    logic [AWIDTH-1:0] beat_idx;

    assign s_ready   = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign accept    = s_valid && s_ready;
    assign last_beat = accept && beat_tc;

    loader_beat_counter #(
        .CWIDTH (AWIDTH)
    ) u_beat_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr_i  ((state_q == IDLE) || last_beat),
        .inc_i  (accept),
        .last_i ((state_q == LOAD_A) ? A_LAST : B_LAST),
        .idx_o  (beat_idx),
        .tc_o   (beat_tc)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q;
    logic          err_q;
    logic          tmo_hit;

    assign tmo_hit = (state_q == RUN) && !done_mat_mul && (tmo_q == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q != RUN) begin
                tmo_q <= TMO_LOAD;
            end else if (tmo_q != '0) begin
                tmo_q <= tmo_q - 1'b1;
            end
            if ((state_q == IDLE) && cmd_go) begin
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = err_q;
`else
    logic tmo_hit;
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_go) state_d = LOAD_A;
            LOAD_A:  if (last_beat) state_d = LOAD_B;
            LOAD_B:  if (last_beat) state_d = SETTLE;
            SETTLE:  if (settle_q == '0) state_d = RUN;
            RUN: begin
                if (done_mat_mul) begin
                    state_d = FINISH;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            addr_q   <= '0;
            we_a_q   <= 1'b0;
            we_b_q   <= 1'b0;
            en_q     <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q <= state_d;
            we_a_q  <= accept && (state_q == LOAD_A);
            we_b_q  <= accept && (state_q == LOAD_B);
            // stays up across stalls and the A->B hand-off, drops once loading is over
            en_q    <= accept || (en_q && s_ready);
            if (accept) begin
                data_q <= s_data;
                addr_q <= beat_idx;
            end
            if (state_q != SETTLE) begin
                settle_q <= SETTLE_LOAD;
            end else if (settle_q != '0) begin
                settle_q <= settle_q - 8'd1;
            end
        end
    end

    assign data_pi               = data_q;
    assign addr_pi               = addr_q;
    assign we_a                  = we_a_q;
    assign we_b                  = we_b_q;
    assign enable_writing_to_mem = en_q;
    assign start_mat_mul         = (state_q == RUN);
    assign busy                  = (state_q != IDLE);
    assign done_pulse            = (state_q == FINISH);

endmodule
